pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline control unit for the five-stage core. Merges per-stage stall requests into the 6-bit stall vector that freezes PC/IF/ID/EX/MEM/WB. Sequences trap, `mret` and interrupt redirects: drains outstanding memory traffic, then issues a one-cycle flush with the redirect PC. Drives the fetch unit's `stall_i`, `flush_i` and `new_pc_i` inputs, and feeds the same stall/flush to every pipeline register.

## Interface
- `ADDR_W`, 32, PC width.
- `RESET_PC`, 32'h0000_0000, value of `new_pc_o` and of the latched target after reset.
- `DRAIN_MAX`, 16, maximum DRAIN cycles before a forced flush; range 1..255.
- `clk_i` in 1, single clock, all state on rising edge.
- `rst_i` in 1, synchronous, active-high reset.
- `stall_req_if_i` in 1, fetch stage not ready.
- `stall_req_id_i` in 1, decode hazard (load-use).
- `stall_req_ex_i` in 1, multi-cycle EX op (div).
- `stall_req_mem_i` in 1, MEM stage waiting on bus.
- `pc_next_i` in ADDR_W, sequential/predicted next PC from the branch predictor.
- `trap_req_i` in 1, synchronous exception committed in MEM; level, held until flushed.
- `trap_vec_i` in ADDR_W, trap vector from CSR.
- `mret_i` in 1, `mret` committed in MEM.
- `mepc_i` in ADDR_W, return PC from CSR.
- `irq_i` in 1, enabled and pending external interrupt.
- `mem_busy_i` in 1, data bus transaction outstanding.
- `stall_o` out 6, bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = hold.
- `flush_o` out 1, kill IF..MEM contents and load `new_pc_o`.
- `new_pc_o` out ADDR_W, next PC for the fetch unit.
- `trap_ack_o` out 1, one-cycle pulse; CSR latches mepc/mcause (trap/irq) or restores mstatus (mret).
- `timeout_o` out 1, sticky; DRAIN ended by watchdog.

## Operation
- States: IDLE, DRAIN, FLUSH. All outputs are Moore-decoded from the state register, except the `new_pc_o` mux and the IDLE stall vector, which are combinational.
- **IDLE, stall vector:** the deepest active request wins.
  - mem → 6'b011111
  - ex → 6'b001111
  - id → 6'b000111
  - if → 6'b000011
  - none → 6'b000000
- **IDLE, event priority:** `trap_req_i` > `mret_i` > `irq_i`.
  - `irq_i` is taken only when no stall request is active.
  - On an event, latch `target_q` (trap or irq → `trap_vec_i`; mret → `mepc_i`).
  - Record the kind in `kind_q`. Clear `drain_cnt`.
  - Next state is DRAIN if `mem_busy_i`, else FLUSH.
  - In the event cycle, `stall_o` = 6'b111111.
- **DRAIN:** `stall_o` = 6'b111111 and `drain_cnt` increments each cycle.
  - Exit to FLUSH when `mem_busy_i` = 0.
  - If `drain_cnt` reaches DRAIN_MAX-1 while still busy, exit to FLUSH and set `timeout_o`.
  - All new events are ignored.
- **FLUSH:** `flush_o` = 1, `trap_ack_o` = 1, `stall_o` = 0, `new_pc_o` = `target_q`. Next state is IDLE unconditionally. Events present this cycle are ignored; they belong to flushed instructions.
- Outside FLUSH, `new_pc_o` = `pc_next_i`.
- `stall_req_*` inputs are don't-care outside IDLE.
- Reset mid-DRAIN or mid-FLUSH: state returns to IDLE and nothing is pending. `trap_ack_o` is never pulsed for the aborted event.

## Timing
- Reset values: state IDLE, `stall_o` 0, `flush_o` 0, `trap_ack_o` 0, `timeout_o` 0, `target_q` RESET_PC, `new_pc_o` = `pc_next_i`.
- Stall requests to `stall_o`: 0 cycles (combinational).
- Event to flush, idle bus: event at cycle N, FLUSH at N+1. The IFU loads the target at the edge ending N+1, and the target is fetched at N+2.
- Event to flush, busy bus: FLUSH occurs one cycle after the first cycle in DRAIN with `mem_busy_i` = 0. The worst case is N+1+DRAIN_MAX.
- Back-to-back: the earliest next event is accepted at FLUSH+1.
- `trap_ack_o` and `flush_o` are always coincident, one cycle wide.

## Configuration
- `PIPE_CTRL_IRQ_EN` defined: `irq_i` participates as above.
- Not defined: `irq_i` is ignored, the port is retained, and `kind_q` never encodes irq; traps and mret behave identically.

## Test plan
- **Stall merge:** IDLE with `stall_req_id_i`=1 and `stall_req_ex_i`=1 → `stall_o`=6'b001111 in the same cycle, and `flush_o`=0.
- **Trap, idle bus:**
  - Stimulus: `trap_req_i`=1, `trap_vec_i`=32'h0000_0100, `mem_busy_i`=0 at cycle 5.
  - Response: `stall_o`=6'b111111 at 5; `flush_o`=1, `trap_ack_o`=1 and `new_pc_o`=32'h100 at 6; IDLE at 7.
- **Drain:**
  - Stimulus: `mret_i`=1, `mepc_i`=32'h0000_2004, `mem_busy_i` high for 3 cycles.
  - Response: DRAIN with `stall_o`=6'b111111 for 3 cycles, then FLUSH with `new_pc_o`=32'h2004, and `timeout_o`=0.
- **Watchdog:**
  - Stimulus: DRAIN_MAX=4, trap with `mem_busy_i` stuck at 1.
  - Response: FLUSH after exactly 4 DRAIN cycles, and `timeout_o`=1 until `rst_i`.
- **Priority:**
  - Stimulus: `trap_req_i`, `mret_i` and `irq_i` all 1 in the same cycle.
  - Response: target = `trap_vec_i`. An `irq_i` held during a FLUSH cycle is not accepted until the following IDLE cycle.
- **Gating and reset:**
  - `irq_i`=1 with `stall_req_mem_i`=1 → no event; `stall_o`=6'b011111.
  - With `PIPE_CTRL_IRQ_EN` undefined, `irq_i`=1 alone → no flush.
  - `rst_i` asserted during DRAIN → IDLE next cycle and no `trap_ack_o`.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - pipeline control bundle between the core stages and pipe_ctrl
interface pipe_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              stall_req_if_i;
  logic              stall_req_id_i;
  logic              stall_req_ex_i;
  logic              stall_req_mem_i;
  logic [ADDR_W-1:0] pc_next_i;
  logic              trap_req_i;
  logic [ADDR_W-1:0] trap_vec_i;
  logic              mret_i;
  logic [ADDR_W-1:0] mepc_i;
  logic              irq_i;
  logic              mem_busy_i;
  logic [5:0]        stall_o;
  logic              flush_o;
  logic [ADDR_W-1:0] new_pc_o;
  logic              trap_ack_o;
  logic [1:0]        trap_kind_o;
  logic              timeout_o;

  modport master (
    output stall_req_if_i, stall_req_id_i, stall_req_ex_i, stall_req_mem_i,
    output pc_next_i, trap_req_i, trap_vec_i, mret_i, mepc_i, irq_i, mem_busy_i,
    input  stall_o, flush_o, new_pc_o, trap_ack_o, trap_kind_o, timeout_o
  );

  modport slave (
    input  stall_req_if_i, stall_req_id_i, stall_req_ex_i, stall_req_mem_i,
    input  pc_next_i, trap_req_i, trap_vec_i, mret_i, mepc_i, irq_i, mem_busy_i,
    output stall_o, flush_o, new_pc_o, trap_ack_o, trap_kind_o, timeout_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - stall merge and trap/mret/irq redirect sequencer (irq gated by PIPE_CTRL_IRQ_EN)
// trap_kind_o (0 trap, 1 mret, 2 irq) is valid with trap_ack_o so the CSR file can pick mcause/mstatus handling.
module pipe_ctrl #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                DRAIN_MAX = 16
) (
  input logic         clk_i,
  input logic         rst_i,
  pipe_ctrl_if.slave  bus
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam logic [1:0] KIND_TRAP = 2'd0;
  localparam logic [1:0] KIND_MRET = 2'd1;
  localparam logic [1:0] KIND_IRQ  = 2'd2;

  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_MAX - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic [1:0]        kind_q, kind_d;
  logic [7:0]        drain_cnt_q, drain_cnt_d;
  logic              timeout_q, timeout_d;

  logic              any_stall_req;
  logic              irq_take;
  logic              event_take;
  logic [5:0]        idle_stall;

  always_comb begin
    any_stall_req = bus.stall_req_if_i | bus.stall_req_id_i |
                    bus.stall_req_ex_i | bus.stall_req_mem_i;
`ifdef PIPE_CTRL_IRQ_EN
    irq_take = bus.irq_i & ~any_stall_req;
`else
    irq_take = 1'b0;
`endif
    event_take = bus.trap_req_i | bus.mret_i | irq_take;

    // Deepest stalled stage freezes itself and everything upstream of it.
    if (bus.stall_req_mem_i)     idle_stall = 6'b011111;
    else if (bus.stall_req_ex_i) idle_stall = 6'b001111;
    else if (bus.stall_req_id_i) idle_stall = 6'b000111;
    else if (bus.stall_req_if_i) idle_stall = 6'b000011;
    else                         idle_stall = 6'b000000;
  end

  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    kind_d      = kind_q;
    drain_cnt_d = drain_cnt_q;
    timeout_d   = timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (event_take) begin
          if (bus.trap_req_i) begin
            target_d = bus.trap_vec_i;
            kind_d   = KIND_TRAP;
          end else if (bus.mret_i) begin
            target_d = bus.mepc_i;
            kind_d   = KIND_MRET;
          end else begin
            target_d = bus.trap_vec_i;
            kind_d   = KIND_IRQ;
          end
          drain_cnt_d = 8'd0;
          state_d     = bus.mem_busy_i ? ST_DRAIN : ST_FLUSH;
        end
      end
      ST_DRAIN: begin
        drain_cnt_d = drain_cnt_q + 8'd1;
        if (!bus.mem_busy_i) begin
          state_d = ST_FLUSH;
        end else if (drain_cnt_q == DRAIN_LAST) begin
          state_d   = ST_FLUSH;
          timeout_d = 1'b1;
        end
      end
      ST_FLUSH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      target_q    <= RESET_PC;
      kind_q      <= KIND_TRAP;
      drain_cnt_q <= 8'd0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      kind_q      <= kind_d;
      drain_cnt_q <= drain_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.stall_o     = (state_q == ST_IDLE)  ? (event_take ? 6'b111111 : idle_stall) :
                           (state_q == ST_DRAIN) ? 6'b111111 : 6'b000000;
  assign bus.flush_o     = (state_q == ST_FLUSH);
  assign bus.trap_ack_o  = (state_q == ST_FLUSH);
  assign bus.new_pc_o    = (state_q == ST_FLUSH) ? target_q : bus.pc_next_i;
  assign bus.trap_kind_o = kind_q;
  assign bus.timeout_o   = timeout_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard bench for pipe_ctrl with a transaction-level reference model
module tb_pipe_ctrl;
  localparam int DRAIN_MAX = 4;

  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic        tmo;
    logic [1:0]  kind;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic tmo_m = 1'b0;
  exp_t expq[$];

  always #5 clk = ~clk;

  pipe_ctrl_if #(.ADDR_W(32)) bus ();

  pipe_ctrl #(.ADDR_W(32), .RESET_PC(32'h0), .DRAIN_MAX(DRAIN_MAX)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  function automatic logic [5:0] deepest(input logic f, input logic d, input logic e, input logic m);
    if (m) return 6'b011111;
    if (e) return 6'b001111;
    if (d) return 6'b000111;
    if (f) return 6'b000011;
    return 6'b000000;
  endfunction

  task automatic cyc_start();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bg();
    bus.stall_req_if_i  = 1'($urandom);
    bus.stall_req_id_i  = 1'($urandom);
    bus.stall_req_ex_i  = 1'($urandom);
    bus.stall_req_mem_i = 1'($urandom);
    bus.pc_next_i       = $urandom;
    bus.trap_vec_i      = $urandom;
    bus.mepc_i          = $urandom;
    bus.mem_busy_i      = 1'($urandom);
  endtask

  task automatic push(input logic [5:0] s, input logic f, input logic [31:0] pc,
                      input logic [1:0] k, input string tag);
    exp_t e;
    e.stall = s; e.flush = f; e.pc = pc; e.tmo = tmo_m; e.kind = k; e.tag = tag;
    expq.push_back(e);
  endtask

  task automatic idle_fixed(input logic f, input logic d, input logic e, input logic m,
                            input logic irq, input string tag);
    cyc_start();
    drive_bg();
    bus.stall_req_if_i = f; bus.stall_req_id_i = d;
    bus.stall_req_ex_i = e; bus.stall_req_mem_i = m;
    bus.trap_req_i = 1'b0; bus.mret_i = 1'b0; bus.irq_i = irq;
    push(deepest(f, d, e, m), 1'b0, bus.pc_next_i, 2'd0, tag);
  endtask

  task automatic do_idle(input int n);
    for (int i = 0; i < n; i++) begin
      cyc_start();
      drive_bg();
      bus.trap_req_i = 1'b0;
      bus.mret_i     = 1'b0;
`ifdef PIPE_CTRL_IRQ_EN
      bus.irq_i = (bus.stall_req_if_i | bus.stall_req_id_i | bus.stall_req_ex_i |
                   bus.stall_req_mem_i) ? 1'($urandom) : 1'b0;
`else
      bus.irq_i = 1'($urandom);
`endif
      push(deepest(bus.stall_req_if_i, bus.stall_req_id_i, bus.stall_req_ex_i,
                   bus.stall_req_mem_i), 1'b0, bus.pc_next_i, 2'd0, "idle");
    end
  endtask

  // kind: 0 trap, 1 mret, 2 irq; busy_len cycles of mem_busy_i starting at the event cycle.
  task automatic do_event(input int kind, input int busy_len, input logic [31:0] vec,
                          input bit all_on, input string tag);
    int nd;
    cyc_start();
    drive_bg();
    bus.trap_req_i = 1'($urandom); bus.mret_i = 1'($urandom); bus.irq_i = 1'($urandom);
    if (kind == 0) begin
      bus.trap_req_i = 1'b1;
      bus.trap_vec_i = vec;
      if (all_on) begin bus.mret_i = 1'b1; bus.irq_i = 1'b1; end
    end else if (kind == 1) begin
      bus.trap_req_i = 1'b0;
      bus.mret_i     = 1'b1;
      bus.mepc_i     = vec;
    end else begin
      bus.trap_req_i = 1'b0; bus.mret_i = 1'b0; bus.irq_i = 1'b1;
      bus.trap_vec_i = vec;
      bus.stall_req_if_i = 1'b0; bus.stall_req_id_i = 1'b0;
      bus.stall_req_ex_i = 1'b0; bus.stall_req_mem_i = 1'b0;
    end
    bus.mem_busy_i = (busy_len > 0);
    push(6'b111111, 1'b0, bus.pc_next_i, 2'd0, {tag, "_evt"});
    nd = (busy_len < DRAIN_MAX) ? busy_len : DRAIN_MAX;
    for (int k = 0; k < nd; k++) begin
      cyc_start();
      drive_bg();
      bus.trap_req_i = 1'($urandom); bus.mret_i = 1'($urandom); bus.irq_i = 1'($urandom);
      bus.mem_busy_i = (k + 1 < busy_len);
      push(6'b111111, 1'b0, bus.pc_next_i, 2'd0, {tag, "_drain"});
    end
    if (busy_len > DRAIN_MAX) tmo_m = 1'b1;
    cyc_start();
    drive_bg();
    bus.trap_req_i = 1'($urandom); bus.mret_i = 1'($urandom); bus.irq_i = 1'($urandom);
    push(6'b000000, 1'b1, vec, 2'(kind), {tag, "_flush"});
  endtask

  task automatic reset_in_drain();
    do_idle(1);
    cyc_start();
    drive_bg();
    bus.trap_req_i = 1'b1; bus.mret_i = 1'b0; bus.irq_i = 1'b0; bus.mem_busy_i = 1'b1;
    push(6'b111111, 1'b0, bus.pc_next_i, 2'd0, "rst_evt");
    cyc_start();
    drive_bg();
    bus.mem_busy_i = 1'b1;
    push(6'b111111, 1'b0, bus.pc_next_i, 2'd0, "rst_drain");
    cyc_start();
    drive_bg();
    rst = 1'b1;
    bus.mem_busy_i = 1'b1;
    push(6'b111111, 1'b0, bus.pc_next_i, 2'd0, "rst_cycle");
    tmo_m = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc_start();
      rst = 1'b0;
      drive_bg();
      bus.stall_req_if_i = 1'b0; bus.stall_req_id_i = 1'b0;
      bus.stall_req_ex_i = 1'b0; bus.stall_req_mem_i = 1'b0;
      bus.trap_req_i = 1'b0; bus.mret_i = 1'b0; bus.irq_i = 1'b0;
      push(6'b000000, 1'b0, bus.pc_next_i, 2'd0, "after_rst");
    end
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      checks++;
      if (bus.stall_o !== e.stall) begin
        errors++;
        $display("FAIL %s stall_o got %b want %b", e.tag, bus.stall_o, e.stall);
      end
      checks++;
      if (bus.flush_o !== e.flush || bus.trap_ack_o !== e.flush) begin
        errors++;
        $display("FAIL %s flush/ack got %b/%b want %b", e.tag, bus.flush_o, bus.trap_ack_o, e.flush);
      end
      checks++;
      if (bus.new_pc_o !== e.pc) begin
        errors++;
        $display("FAIL %s new_pc_o got %h want %h", e.tag, bus.new_pc_o, e.pc);
      end
      checks++;
      if (bus.timeout_o !== e.tmo) begin
        errors++;
        $display("FAIL %s timeout_o got %b want %b", e.tag, bus.timeout_o, e.tmo);
      end
      if (e.flush) begin
        checks++;
        if (bus.trap_kind_o !== e.kind) begin
          errors++;
          $display("FAIL %s trap_kind_o got %0d want %0d", e.tag, bus.trap_kind_o, e.kind);
        end
      end
    end
  end

  initial begin
    drive_bg();
    bus.trap_req_i = 1'b0; bus.mret_i = 1'b0; bus.irq_i = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    cyc_start();
    bus.stall_req_if_i = 1'b0; bus.stall_req_id_i = 1'b0;
    bus.stall_req_ex_i = 1'b0; bus.stall_req_mem_i = 1'b0;
    bus.pc_next_i = $urandom;
    push(6'b000000, 1'b0, bus.pc_next_i, 2'd0, "reset");
    cyc_start();
    rst = 1'b0;
    bus.pc_next_i = $urandom;
    push(6'b000000, 1'b0, bus.pc_next_i, 2'd0, "post_reset");

    idle_fixed(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "stall_merge");
    idle_fixed(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "stall_if");
    idle_fixed(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "irq_gated_mem");
`ifndef PIPE_CTRL_IRQ_EN
    idle_fixed(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "irq_disabled");
`else
    do_event(2, 0, 32'h0000_0080, 1'b0, "irq_alone");
`endif
    do_event(0, 0, 32'h0000_0100, 1'b0, "trap_idle_bus");
    do_idle(1);
    do_event(1, 3, 32'h0000_2004, 1'b0, "mret_drain");
    do_event(0, DRAIN_MAX, 32'h0000_0200, 1'b0, "drain_edge");
    do_event(0, 0, 32'h0000_0300, 1'b1, "priority");
    do_event(0, 20, 32'h0000_0400, 1'b0, "watchdog");
    do_idle(2);
    reset_in_drain();

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        do_idle(int'($urandom_range(1, 3)));
      end else begin
`ifdef PIPE_CTRL_IRQ_EN
        do_event(int'($urandom_range(0, 2)), int'($urandom_range(0, 7)), $urandom, 1'b0, "rnd");
`else
        do_event(int'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom, 1'b0, "rnd");
`endif
      end
    end
    do_idle(1);

    repeat (2) @(posedge clk);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain_queue left %0d want 0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
